// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the two-master memory arbiter:
//   arb_state_e : arbitration FSM encoding (free, owned by master 0, owned by master 1)
//   M0 / M1     : master id constants
//   rd_tag_t    : read-return tag {valid, id} carried alongside the RAM read latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe
// RD_LAT-deep shift register of read tags. The tag for an access enters at the
// grant edge and leaves RD_LAT cycles later, aligned with the RAM read data.
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-low clear (drops every tag in flight)
//   tag_in  : tag of the access performed at this edge
//   tag_out : tag whose read data is on mem_din this cycle
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t tag_p [RD_LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous RAM port between master 0 (processor) and master 1
// (loader/debug). At most one access is granted per cycle; ties in the free
// state alternate using the `last` register; a granted access with lock=1
// keeps ownership until the owner drops lock or req. Read data is routed back
// to the issuing master after the RAM's RD_LAT cycle latency.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   mX_req/lock/we/addr/wdata : master X request, lock, write enable, address, write data
//   mX_gnt                    : access accepted this cycle (combinational)
//   mX_rvalid/rdata           : read data return for master X
//   mem_addr/dout/we          : RAM command, driven by the winner (zero when idle)
//   mem_din                   : RAM read data, RD_LAT cycles after address sampling
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_we,
  input  logic [DW-1:0] mem_din
);

  arb_state_e state_q;
  logic       last_q;
  logic       gnt0;
  logic       gnt1;
  rd_tag_t    tag_in;
  rd_tag_t    tag_out;

  // Grant decision; suppressed while reset is asserted so no access leaks out.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            if (last_q == M1) gnt0 = 1'b1;
            else              gnt1 = 1'b1;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    mem_addr = '0;
    mem_dout = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = m0_addr;
      mem_dout = m0_wdata;
      mem_we   = m0_we;
    end else if (gnt1) begin
      mem_addr = m1_addr;
      mem_dout = m1_wdata;
      mem_we   = m1_we;
    end
  end

  // Ownership FSM and fairness register. Dropping req in an owned state
  // releases immediately; no grant happens in that cycle because the
  // grant logic only considers the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= M1;
    end else begin
      if (gnt0)      last_q <= M0;
      else if (gnt1) last_q <= M1;
      case (state_q)
        IDLE: begin
          if (gnt0 && m0_lock)      state_q <= OWN0;
          else if (gnt1 && m1_lock) state_q <= OWN1;
        end
        OWN0:    if (!m0_req || !m0_lock) state_q <= IDLE;
        OWN1:    if (!m1_req || !m1_lock) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant stage -> tag pipeline: only granted reads produce a return.
  assign tag_in.valid = (gnt0 && !m0_we) || (gnt1 && !m1_we);
  assign tag_in.id    = gnt1 ? M1 : M0;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Return stage: tag and RAM data are aligned here.
  assign m0_rvalid = tag_out.valid && (tag_out.id == M0);
  assign m1_rvalid = tag_out.valid && (tag_out.id == M1);
  assign m0_rdata  = mem_din;
  assign m1_rdata  = mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives four arbiter instances (RD_LAT = 1..4) with identical master traffic.
// Each instance has its own behavioural RAM; expected read returns are queued
// per instance when a read grant is expected and popped when rvalid appears.
module tb_mem_arbiter;

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_we;
  logic [15:0] m0_addr, m0_wdata;
  logic        m1_req, m1_lock, m1_we;
  logic [15:0] m1_addr, m1_wdata;

  logic [3:0]  g0_v, g1_v, rv0_v, rv1_v, we_v;
  logic [15:0] rd0_v [4];
  logic [15:0] rd1_v [4];
  logic [15:0] maddr_v [4];

  logic [15:0] shadow [256];
  exp_t        exp_q [4][$];
  int          cyc;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  for (genvar i = 0; i < 4; i++) begin : g_lat
    localparam int L = i + 1;
    logic [15:0] mem_addr, mem_dout, mem_din;
    logic        mem_we;
    logic [15:0] ram [256];
    logic [15:0] rp [L];
    exp_t        e;

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_lock   (m0_lock),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m1_req    (m1_req),
      .m1_lock   (m1_lock),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m0_gnt    (g0_v[i]),
      .m1_gnt    (g1_v[i]),
      .m0_rvalid (rv0_v[i]),
      .m0_rdata  (rd0_v[i]),
      .m1_rvalid (rv1_v[i]),
      .m1_rdata  (rd1_v[i]),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_we    (mem_we),
      .mem_din   (mem_din)
    );

    assign we_v[i]    = mem_we;
    assign maddr_v[i] = mem_addr;
    assign mem_din    = rp[L-1];

    initial for (int a = 0; a < 256; a++) ram[a] = 16'(16'hA000 + a);

    always @(posedge clk) begin
      rp[0] <= ram[mem_addr[7:0]];
      for (int k = 1; k < L; k++) rp[k] <= rp[k-1];
      if (mem_we) ram[mem_addr[7:0]] <= mem_dout;
    end

    always @(negedge clk) begin
      if (rv0_v[i] || rv1_v[i]) begin
        if (exp_q[i].size() == 0) begin
          chk($sformatf("rv_unexp_L%0d", L), {rv1_v[i], rv0_v[i]}, 0);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("rv_sel_L%0d", L), {rv1_v[i], rv0_v[i]}, e.id ? 2'b10 : 2'b01);
          chk($sformatf("rv_data_L%0d", L), e.id ? rd1_v[i] : rd0_v[i], e.data);
          chk($sformatf("rv_lat_L%0d", L), cyc, e.due);
        end
      end
    end
  end

  task automatic step(input logic r0, input logic l0, input logic w0,
                      input logic [15:0] a0, input logic [15:0] d0,
                      input logic r1, input logic l1, input logic w1,
                      input logic [15:0] a1, input logic [15:0] d1,
                      input logic eg0, input logic eg1);
    exp_t ex;
    @(posedge clk);
    #1;
    m0_req = r0; m0_lock = l0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge clk);
    chk("gnt0", g0_v, {4{eg0}});
    chk("gnt1", g1_v, {4{eg1}});
    if (eg0 || eg1) begin
      chk("mem_addr", maddr_v[0], eg0 ? a0 : a1);
      chk("mem_we", we_v, {4{eg0 ? w0 : w1}});
      if ((eg0 && !w0) || (eg1 && !w1)) begin
        ex.id   = eg1;
        ex.data = shadow[eg0 ? a0[7:0] : a1[7:0]];
        for (int i = 0; i < 4; i++) begin
          ex.due = cyc + i + 1;
          exp_q[i].push_back(ex);
        end
      end
      if (eg0 && w0) shadow[a0[7:0]] = d0;
      if (eg1 && w1) shadow[a1[7:0]] = d1;
    end else begin
      chk("mem_idle", {we_v, maddr_v[0]}, 0);
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int a = 0; a < 256; a++) shadow[a] = 16'(16'hA000 + a);
    reset = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    // Reset state: requests present but nothing granted or returned.
    repeat (2) @(posedge clk);
    #1;
    m0_req = 1; m0_we = 1; m1_req = 1;
    @(negedge clk);
    chk("rst_gnt", {g1_v, g0_v}, 0);
    chk("rst_we", we_v, 0);
    chk("rst_rv", {rv1_v, rv0_v}, 0);
    #1;
    m0_req = 0; m0_we = 0; m1_req = 0;
    @(negedge clk);
    reset = 1'b1;

    // Single master write then read-back.
    step(1, 0, 1, 16'h0010, 16'h1234, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 16'h0010, 0,        0, 0, 0, 0, 0, 1, 0);
    repeat (5) idle_step();

    // m1 alone, then six contested cycles alternating from m0.
    step(0, 0, 0, 0, 0, 1, 0, 0, 16'h0011, 0, 0, 1);
    for (int k = 0; k < 6; k++)
      step(1, 0, 0, 16'(16'h0040 + k), 0, 1, 0, 0, 16'(16'h0050 + k), 0,
           (k % 2) == 0, (k % 2) == 1);
    repeat (5) idle_step();

    // Locked read-modify-write by m1 while m0 keeps requesting.
    step(1, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 16'h0030, 0, 1, 1, 0, 16'h0020, 0,        0, 1);
    step(1, 0, 0, 16'h0030, 0, 1, 0, 1, 16'h0020, 16'h0021, 0, 1);
    step(1, 0, 0, 16'h0020, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (5) idle_step();

    // Lock released by dropping req: no grant in the release cycle.
    step(1, 1, 0, 16'h0005, 0, 0, 0, 0, 0,        0, 1, 0);
    step(0, 0, 0, 0,        0, 1, 0, 0, 16'h0006, 0, 0, 0);
    step(0, 0, 0, 0,        0, 1, 0, 0, 16'h0006, 0, 0, 1);
    repeat (5) idle_step();

    // Reset one cycle after a read grant: that read must never return.
    step(1, 0, 0, 16'h0007, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    repeat (2) @(negedge clk);
    chk("rst2_rv", {rv1_v, rv0_v}, 0);
    reset = 1'b1;
    repeat (5) idle_step();
    step(1, 0, 0, 16'h0001, 0, 1, 0, 0, 16'h0002, 0, 1, 0);
    step(1, 0, 0, 16'h0001, 0, 1, 0, 0, 16'h0002, 0, 0, 1);
    repeat (5) idle_step();

    // Back-to-back reads of addresses 0..7 on every latency.
    for (int a = 0; a < 8; a++) step(1, 0, 0, 16'(a), 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (6) idle_step();

    for (int i = 0; i < 4; i++) chk($sformatf("q_empty_L%0d", i + 1), exp_q[i].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
